onehot_req_encoder: RTL and testbench



---
 rtl/onehot_req_encoder.sv | 68 ++++++
 tb/tb_onehot_req_encoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/onehot_req_encoder.sv
// Funnels one-hot/multi-hot request pulses into a valid/ready stream of binary
// indices, one pending event per line, issued in round-robin order.
module onehot_req_encoder #(
    parameter int BINARY_BITS = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [(2**BINARY_BITS)-1:0]   set,
    input  logic                          flush,
    input  logic                          ready,
    output logic                          valid,
    output logic [BINARY_BITS-1:0]        binary,
    output logic [(2**BINARY_BITS)-1:0]   pending,
    output logic                          coalesce
);
    localparam int N = 2**BINARY_BITS;

    logic [BINARY_BITS-1:0] ptr;
    logic                   load;
    logic                   found;
    logic [BINARY_BITS-1:0] grant_idx;
    logic [BINARY_BITS-1:0] idx;
    logic [N-1:0]           grant;

    // Rotating search starting at ptr; index arithmetic wraps mod N by width.
    always_comb begin
        load      = !valid || ready;
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + k[BINARY_BITS-1:0];
            if (load && !found && pending[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant = found ? (N'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending  <= '0;
            valid    <= 1'b0;
            binary   <= '0;
            coalesce <= 1'b0;
            ptr      <= '0;
        end else if (flush) begin
            pending  <= '0;
            valid    <= 1'b0;
            coalesce <= 1'b0;
            ptr      <= '0;
        end else begin
            // A set landing on the bit being granted re-pends it rather than coalescing.
            pending  <= (pending & ~grant) | set;
            coalesce <= |(set & pending & ~grant);
            if (load) begin
                if (found) begin
                    valid  <= 1'b1;
                    binary <= grant_idx;
                    ptr    <= grant_idx + 1'b1;
                end else begin
                    valid  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_onehot_req_encoder.sv
// Directed bench for onehot_req_encoder: hand-computed expectations per edge.
module tb_onehot_req_encoder;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] set;
    logic       flush;
    logic       ready;
    logic       valid;
    logic [2:0] binary;
    logic [7:0] pending;
    logic       coalesce;

    int errors = 0;
    int checks = 0;

    onehot_req_encoder #(.BINARY_BITS(3)) dut (
        .clk(clk), .resetn(resetn), .set(set), .flush(flush), .ready(ready),
        .valid(valid), .binary(binary), .pending(pending), .coalesce(coalesce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, binary, pending, coalesce in one call
    task automatic chk_all(input string tag, input logic v, input logic [2:0] b,
                           input logic [7:0] p, input logic c);
        chk({tag, ".valid"}, 32'(v), 32'(valid));
        chk({tag, ".binary"}, 32'(b), 32'(binary));
        chk({tag, ".pending"}, 32'(p), 32'(pending));
        chk({tag, ".coalesce"}, 32'(c), 32'(coalesce));
    endtask

    initial begin
        resetn = 1'b0; set = '0; flush = 1'b0; ready = 1'b0;
        #2;
        chk_all("reset0", 1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // single request
        ready = 1'b1; set = 8'h04;
        tick(); set = '0;
        chk_all("single.pend", 1'b0, 3'd0, 8'h04, 1'b0);
        tick();
        chk_all("single.issue", 1'b1, 3'd2, 8'h00, 1'b0);
        tick();
        chk("single.drop", 32'(valid), 32'd0);

        // multi-hot after flush restores ptr=0
        flush = 1'b1;
        tick(); flush = 1'b0; set = 8'hA1;
        tick(); set = '0;
        chk("multi.pend", 32'(pending), 32'hA1);
        tick();
        chk_all("multi.i0", 1'b1, 3'd0, 8'hA0, 1'b0);
        tick();
        chk_all("multi.i5", 1'b1, 3'd5, 8'h80, 1'b0);
        tick();
        chk_all("multi.i7", 1'b1, 3'd7, 8'h00, 1'b0);
        tick();
        chk("multi.drop", 32'(valid), 32'd0);

        // round-robin: issue 3 (ptr=4), then 0x09 -> 0 then 3
        set = 8'h08;
        tick(); set = '0;
        tick();
        chk("rr.i3", 32'(binary), 32'd3);
        set = 8'h09;
        tick(); set = '0;
        chk_all("rr.gap", 1'b0, 3'd3, 8'h09, 1'b0);
        tick();
        chk_all("rr.a0", 1'b1, 3'd0, 8'h08, 1'b0);
        tick();
        chk_all("rr.a3", 1'b1, 3'd3, 8'h00, 1'b0);
        tick();
        // move ptr to 7 by issuing 6, then 0x81 -> 7 then 0
        set = 8'h40;
        tick(); set = '0;
        tick();
        chk("rr.i6", 32'(binary), 32'd6);
        tick();
        set = 8'h81;
        tick(); set = '0;
        tick();
        chk_all("rr.b7", 1'b1, 3'd7, 8'h01, 1'b0);
        tick();
        chk_all("rr.b0", 1'b1, 3'd0, 8'h00, 1'b0);
        tick();
        chk("rr.drop", 32'(valid), 32'd0);

        // backpressure and coalesce with binary=1 held (ptr=1)
        set = 8'h02;
        tick(); set = '0; ready = 1'b0;
        tick();
        chk_all("bp.hold", 1'b1, 3'd1, 8'h00, 1'b0);
        set = 8'h02;
        tick();
        chk_all("bp.pend", 1'b1, 3'd1, 8'h02, 1'b0);
        tick(); set = '0;
        chk_all("bp.coal", 1'b1, 3'd1, 8'h02, 1'b1);
        tick();
        chk_all("bp.still", 1'b1, 3'd1, 8'h02, 1'b0);
        ready = 1'b1;
        tick();
        chk_all("bp.again", 1'b1, 3'd1, 8'h00, 1'b0);
        tick();
        chk("bp.drop", 32'(valid), 32'd0);

        // collision: set bit 6 in the cycle 6 is granted (ptr=2)
        set = 8'h40;
        tick();
        tick(); set = '0;
        chk_all("col.first", 1'b1, 3'd6, 8'h40, 1'b0);
        tick();
        chk_all("col.second", 1'b1, 3'd6, 8'h00, 1'b0);
        tick();
        chk("col.drop", 32'(valid), 32'd0);

        // fill to all-ones with valid=1 (ptr=7), then flush with set ignored
        ready = 1'b0; set = 8'hFF;
        tick();
        chk("full.pend", 32'(pending), 32'hFF);
        tick(); set = '0;
        chk_all("full.hold", 1'b1, 3'd7, 8'hFF, 1'b1);
        flush = 1'b1; set = 8'h01; ready = 1'b1;
        tick(); flush = 1'b0; set = '0;
        chk_all("flush", 1'b0, 3'd7, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush.quiet", 32'(valid), 32'd0);
        end
        // ptr cleared by flush: 0x81 issues 0 first
        set = 8'h81;
        tick(); set = '0;
        tick();
        chk("flush.ptr0", 32'(binary), 32'd0);
        tick();
        chk("flush.next7", 32'(binary), 32'd7);
        tick();

        // async reset mid-stream with valid=1, pending=0x0F (ptr=0)
        ready = 1'b0; set = 8'h10;
        tick(); set = 8'h0F;
        tick(); set = '0;
        chk_all("pre.rst", 1'b1, 3'd4, 8'h0F, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk_all("async.rst", 1'b0, 3'd0, 8'h00, 1'b0);
        ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post.rst", 32'(valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
